// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared definitions for the ROM fetch sequencer: FSM state encodings and default widths.
// HALT only exists when ROM_FETCH_HALT_EN is defined.
package rom_fetch_sequencer_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
`ifdef ROM_FETCH_HALT_EN
    ,
    HALT  = 2'd3
`endif
  } fetch_state_t;

endpackage

// File: rtl/rom_fetch_pc.sv
// Program counter for the ROM fetch sequencer: loadable up-counter with an all-ones flag.
module rom_fetch_pc #(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              at_max
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Load beats increment so a load coinciding with a handshake never advances the PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= START_ADDR;
    else if (load)
      pc <= load_addr;
    else if (inc)
      pc <= pc + ONE;
  end

  assign at_max = &pc;

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Fetches bytes from the program ROM and hands them to decode over valid/ready.
// Define ROM_FETCH_HALT_EN to stop at the last address instead of wrapping to 0.
module rom_fetch_sequencer
  import rom_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic                valid,
  input  logic                ready,
  output logic                wrapped,
  output logic                halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              at_max;
  logic              accept;
  logic              pc_inc;

  // valid is high throughout HOLD, so the handshake reduces to HOLD && ready.
  assign accept   = (state == HOLD) && ready;
  assign rom_addr = pc;

`ifdef ROM_FETCH_HALT_EN
  assign pc_inc = accept && !at_max;
`else
  assign pc_inc = accept;
`endif

  rom_fetch_pc #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .inc      (pc_inc),
    .load_addr(load_addr),
    .pc       (pc),
    .at_max   (at_max)
  );

  // A load discards any held word and restarts from IDLE with cleared flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      instr   <= '0;
      oprnd   <= '0;
      valid   <= 1'b0;
      wrapped <= 1'b0;
`ifdef ROM_FETCH_HALT_EN
      halted  <= 1'b0;
`endif
    end else if (load) begin
      state   <= IDLE;
      valid   <= 1'b0;
      wrapped <= 1'b0;
`ifdef ROM_FETCH_HALT_EN
      halted  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en)
            state <= FETCH;
        end
        FETCH: begin
          instr <= rom_data[DATA_W-1:DATA_W/2];
          oprnd <= rom_data[DATA_W/2-1:0];
          valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
`ifdef ROM_FETCH_HALT_EN
            if (at_max) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= en ? FETCH : IDLE;
            end
`else
            if (at_max)
              wrapped <= 1'b1;
            state <= en ? FETCH : IDLE;
`endif
          end
        end
`ifdef ROM_FETCH_HALT_EN
        HALT: state <= HALT;
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ROM_FETCH_HALT_EN
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Self-checking bench for rom_fetch_sequencer against a transaction-level model of the ROM and PC.
module tb_rom_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, en, load, ready;
  logic [11:0] load_addr, rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  instr, oprnd;
  logic        valid, wrapped, halted;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [11:0] modelPc;

  always #5 clk = ~clk;

  assign rom_data = rom_addr[7:0] ^ 8'hA5;

  rom_fetch_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_addr(load_addr),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .instr    (instr),
    .oprnd    (oprnd),
    .valid    (valid),
    .ready    (ready),
    .wrapped  (wrapped),
    .halted   (halted)
  );

  function automatic logic [7:0] romWord(input logic [11:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic ld, input logic rdy, input logic [11:0] addr);
    en        = e;
    load      = ld;
    ready     = rdy;
    load_addr = addr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    int n = 0;
    while (!valid && n < maxCycles) begin
      step();
      n++;
    end
    checkOutput({tag, " valid within bound"}, {31'd0, valid}, 32'd1);
  endtask

  logic [7:0] t2Const [3];
  logic [7:0] held;
  logic       wasValid, rdy;
  logic [11:0] rndAddr;
  int         handshakes;

  initial begin
    t2Const = '{8'hA5, 8'hA4, 8'hA7};
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    step();
    step();
    reset = 1'b0;
    step();
    checkOutput("reset rom_addr", rom_addr, 12'h000);
    checkOutput("reset valid", valid, 1'b0);
    checkOutput("reset wrapped", wrapped, 1'b0);

    // T2 streaming from address 0 with ready high
    $display("[TB] T2 streaming");
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h000);
    step();
    checkOutput("T2 not yet valid", valid, 1'b0);
    step();
    checkOutput("T2 latency", valid, 1'b1);
    modelPc = 12'h000;
    for (int i = 0; i < 6; i++) begin
      checkOutput("T2 word", {instr, oprnd}, romWord(modelPc));
      if (i < 3) checkOutput("T2 const word", {instr, oprnd}, t2Const[i]);
      step();
      checkOutput("T2 gap", valid, 1'b0);
      modelPc++;
      checkOutput("T2 pc", rom_addr, modelPc);
      step();
      checkOutput("T2 valid", valid, 1'b1);
    end

    // T3 backpressure
    $display("[TB] T3 backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    held = {instr, oprnd};
    checkOutput("T3 held word", held, romWord(modelPc));
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("T3 valid held", valid, 1'b1);
      checkOutput("T3 word held", {instr, oprnd}, held);
      checkOutput("T3 pc held", rom_addr, modelPc);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h000);
    step();
    modelPc++;
    checkOutput("T3 valid drop", valid, 1'b0);
    checkOutput("T3 pc once", rom_addr, modelPc);
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    step();
    checkOutput("T3 next valid", valid, 1'b1);
    checkOutput("T3 next word", {instr, oprnd}, romWord(modelPc));

    // T4 load while a word is held
    $display("[TB] T4 load");
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h0F3);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("T4 valid cleared", valid, 1'b0);
    checkOutput("T4 pc loaded", rom_addr, 12'h0F3);
    waitValid("T4", 4);
    checkOutput("T4 word", {instr, oprnd}, 8'h56);

    // T5 rollover at the top of the ROM
    $display("[TB] T5 rollover");
    applyStimulus(1'b1, 1'b1, 1'b1, 12'hFFF);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("T5 load beats ready", rom_addr, 12'hFFF);
    checkOutput("T5 wrapped clear", wrapped, 1'b0);
    waitValid("T5 first", 4);
    checkOutput("T5 first word", {instr, oprnd}, 8'h5A);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'h000);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
`ifdef ROM_FETCH_HALT_EN
    checkOutput("T5 halted", halted, 1'b1);
    checkOutput("T5 pc stays max", rom_addr, 12'hFFF);
    repeat (4) step();
    checkOutput("T5 no second word", valid, 1'b0);
    checkOutput("T5 still halted", halted, 1'b1);
    checkOutput("T5 wrapped never", wrapped, 1'b0);
`else
    checkOutput("T5 wrapped", wrapped, 1'b1);
    checkOutput("T5 pc wrapped", rom_addr, 12'h000);
    checkOutput("T5 halted tied", halted, 1'b0);
    waitValid("T5 second", 4);
    checkOutput("T5 second word", {instr, oprnd}, 8'hA5);
    checkOutput("T5 wrapped sticky", wrapped, 1'b1);
`endif

    // T6 en dropped while holding a word
    $display("[TB] T6 en drop");
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h010);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    checkOutput("T6 halted cleared", halted, 1'b0);
    checkOutput("T6 wrapped cleared", wrapped, 1'b0);
    waitValid("T6", 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    step();
    step();
    checkOutput("T6 valid kept", valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h000);
    step();
    checkOutput("T6 handshake", valid, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    repeat (3) step();
    checkOutput("T6 idle valid", valid, 1'b0);
    checkOutput("T6 pc plus one", rom_addr, 12'h011);

    // Randomized ready against the PC/ROM model
    $display("[TB] random phase");
    handshakes = 0;
    for (int r = 0; r < 3; r++) begin
      rndAddr = 12'($urandom_range(0, 12'hEFF));
      if (r == 0) rndAddr = 12'h000;
`ifndef ROM_FETCH_HALT_EN
      if (r == 2) rndAddr = 12'hFF8;
`endif
      applyStimulus(1'b1, 1'b1, 1'b0, rndAddr);
      step();
      modelPc = rndAddr;
      for (int c = 0; c < 40; c++) begin
        rdy = 1'($urandom_range(0, 1));
        applyStimulus(1'b1, 1'b0, rdy, 12'h000);
        wasValid = valid;
        if (wasValid) checkOutput("RND word", {instr, oprnd}, romWord(modelPc));
        step();
        if (wasValid && rdy) begin
          modelPc++;
          handshakes++;
        end
        checkOutput("RND pc", rom_addr, modelPc);
      end
    end
    checkOutput("RND made progress", {31'd0, handshakes > 0}, 32'd1);

    // T1 asynchronous reset in the middle of HOLD
    $display("[TB] T1 async reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    waitValid("T1 setup", 6);
    #2 reset = 1'b1;
    #1;
    checkOutput("T1 valid", valid, 1'b0);
    checkOutput("T1 instr", instr, 4'h0);
    checkOutput("T1 oprnd", oprnd, 4'h0);
    checkOutput("T1 rom_addr", rom_addr, 12'h000);
    checkOutput("T1 wrapped", wrapped, 1'b0);
    checkOutput("T1 halted", halted, 1'b0);
    step();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
